m_writeback: RTL
================

M_WRITEBACK -- requirements
Module: m_writeback

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, long-unit result buffer depth, power of two, minimum 2.
REQ-002 i_clk  in  1  clock; all state changes on posedge.
REQ-003 i_rst  in  1  reset; asynchronous, active-high.
REQ-004 i_alu_we  in  1  single-cycle ALU result valid; never stalled.
REQ-005 i_alu_ad  in  5  ALU destination register.
REQ-006 i_alu_wd  in  32  ALU result data.
REQ-007 i_iss_valid  in  1  long-latency op issued this cycle; marks destination pending.
REQ-008 i_iss_ad  in  5  destination of the issued long op.
REQ-009 i_lu_valid  in  1  long-unit result offered.
REQ-010 i_lu_ad  in  5  long-unit result destination.
REQ-011 i_lu_wd  in  32  long-unit result data.
REQ-012 o_lu_ready  out  1  long-unit result accepted when i_lu_valid and o_lu_ready are both high.
REQ-013 o_we  out  1  register file write enable, registered.
REQ-014 o_aw  out  5  register file write address, registered.
REQ-015 o_wd  out  32  register file write data, registered.
REQ-016 o_pend  out  32  scoreboard; bit n high = x_n awaits a long-unit result.
REQ-017 o_cnt  out  log2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-018 FIFO: circular, FIFO_DEPTH entries of {ad[4:0], wd[31:0]}, read and write pointers wrap modulo FIFO_DEPTH.
REQ-019 o_lu_ready = (o_cnt != FIFO_DEPTH) and not i_rst; a full FIFO does not accept even when a pop occurs in the same cycle.
REQ-020 Accepted long-unit result with i_lu_ad == 0 is discarded: no push, o_cnt unchanged, no scoreboard change.
REQ-021 Write-port arbitration each cycle, with ALU priority: if i_alu_we and i_alu_ad != 0, the next cycle shows o_we=1, o_aw=i_alu_ad, o_wd=i_alu_wd; else if o_cnt != 0, pop the head and the next cycle shows o_we=1 with the head's ad/wd; else o_we=0.
REQ-022 i_alu_we with i_alu_ad == 0 counts as idle for arbitration; a FIFO pop proceeds in that cycle.
REQ-023 Latency: ALU result to o_we is 1 cycle; long-unit accept to o_we is at least 2 cycles (no bypass; a pop reads only entries stored before the current edge).
REQ-024 When o_we=0, o_aw and o_wd hold their previous values.
REQ-025 Simultaneous push and pop with 0 < o_cnt < FIFO_DEPTH: o_cnt unchanged, both pointers advance.
REQ-026 Scoreboard set: i_iss_valid with i_iss_ad != 0 sets o_pend[i_iss_ad] at the next edge.
REQ-027 Scoreboard clear: a FIFO pop clears o_pend[popped ad] at the same edge the write port is loaded.
REQ-028 Set and clear of the same bit in one cycle: the set wins (bit stays 1).
REQ-029 An ALU write to a pending register is performed and does not change o_pend.
REQ-030 o_pend[0] is constant 0.
REQ-031 FIFO order is preserved; no entry is dropped or duplicated.

Reset
REQ-032 While i_rst=1: o_we=0, o_aw=0, o_wd=0, o_pend=0, o_cnt=0, pointers=0, o_lu_ready=0, all asynchronously.
REQ-033 Reset asserted mid-operation discards all buffered entries and pending bits; nothing is written after deassertion until new inputs arrive.
REQ-034 The first posedge after deassertion samples inputs normally.

Verification
REQ-035 ALU only: i_alu_we=1, ad=5, wd=0xDEADBEEF -> next cycle o_we=1, o_aw=5, o_wd=0xDEADBEEF; o_pend unchanged.
REQ-036 Issue/complete: issue ad=7; 3 cycles later LU result ad=7, wd=0x12345678, ALU idle -> o_pend[7]=1 until the pop edge; o_we=1, o_aw=7, o_wd=0x12345678 two cycles after accept; o_pend[7]=0 afterwards.
REQ-037 Backpressure: ALU writes every cycle, 5 LU results offered with FIFO_DEPTH=4 -> 4 accepted, o_cnt=4, o_lu_ready=0 on the 5th; ALU idle -> drains in order, one entry per cycle, o_cnt reaches 0.
REQ-038 Boundaries: ALU ad=0 while FIFO holds ad=3 -> ad=3 written next cycle; LU ad=0 accepted -> o_cnt unchanged; same-cycle issue ad=9 and pop of ad=9 -> o_pend[9] stays 1.
REQ-039 Reset mid-drain: o_cnt=3, assert i_rst between clock edges -> o_we=0, o_cnt=0, o_pend=0 immediately; after deassertion with idle inputs, o_we stays 0.
REQ-040 Wrap: 10 push/pop rounds with FIFO_DEPTH=4 -> data order preserved across pointer wrap; o_cnt never exceeds 4.

Source files
------------

// File: rtl/m_writeback.sv
// rtl/m_writeback.sv - register file write-back arbiter: ALU path plus buffered long-unit results
// ALU results always win the write port; long-unit results queue in a small FIFO and drain when the ALU is idle.
module m_writeback #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_alu_we,
    input  logic [4:0]                    i_alu_ad,
    input  logic [31:0]                   i_alu_wd,
    input  logic                          i_iss_valid,
    input  logic [4:0]                    i_iss_ad,
    input  logic                          i_lu_valid,
    input  logic [4:0]                    i_lu_ad,
    input  logic [31:0]                   i_lu_wd,
    output logic                          o_lu_ready,
    output logic                          o_we,
    output logic [4:0]                    o_aw,
    output logic [31:0]                   o_wd,
    output logic [31:0]                   o_pend,
    output logic [$clog2(FIFO_DEPTH):0]   o_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [4:0]    mem_ad [FIFO_DEPTH];
    logic [31:0]   mem_wd [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          alu_wr;
    logic          push;
    logic          pop;
    logic [31:0]   pend_next;

    // A full FIFO refuses new results even if a pop frees a slot this cycle.
    assign o_lu_ready = (o_cnt != FULL) && !i_rst;
    assign alu_wr     = i_alu_we && (i_alu_ad != 5'd0);
    assign push       = i_lu_valid && o_lu_ready && (i_lu_ad != 5'd0);
    assign pop        = !alu_wr && (o_cnt != '0);

    always_comb begin
        pend_next = o_pend;
        if (pop)
            pend_next[mem_ad[rd_ptr]] = 1'b0;
        // Applied after the clear so a same-cycle reissue keeps the bit set.
        if (i_iss_valid && (i_iss_ad != 5'd0))
            pend_next[i_iss_ad] = 1'b1;
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_ad[wr_ptr] <= i_lu_ad;
            mem_wd[wr_ptr] <= i_lu_wd;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_we   <= 1'b0;
            o_aw   <= 5'd0;
            o_wd   <= 32'd0;
            o_pend <= 32'd0;
            o_cnt  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            o_pend <= pend_next;
            if (alu_wr) begin
                o_we <= 1'b1;
                o_aw <= i_alu_ad;
                o_wd <= i_alu_wd;
            end else if (pop) begin
                o_we <= 1'b1;
                o_aw <= mem_ad[rd_ptr];
                o_wd <= mem_wd[rd_ptr];
            end else begin
                o_we <= 1'b0;
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   o_cnt <= o_cnt + 1'b1;
                2'b01:   o_cnt <= o_cnt - 1'b1;
                default: o_cnt <= o_cnt;
            endcase
        end
    end
endmodule
